apple2_ram_arbiter: RTL and testbench

Shares the single main/aux RAM port between the Apple II core (CPU and video fetch) and a byte-wide DMA requester, such as the HDD sector buffer or a state loader. The core always has absolute priority and is never stalled. DMA accesses are slotted into cycles where the core does not request RAM, using a valid/ready handshake and a registered read-data return. An optional power-up sequencer clears RAM before the core is released. The block sits between the `apple2` core's RAM bus and the top-level `ram_*` ports.

---
 rtl/apple2_ram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_apple2_ram_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apple2_ram_arbiter.sv
// rtl/apple2_ram_arbiter.sv - core-priority RAM arbiter with DMA slot-in and optional power-up clear (APPLE2_RAM_CLEAR_EN)
module apple2_ram_arbiter #(
    parameter int RD_LAT       = 1,
    parameter int CLEAR_DEPTH  = 262144,
    parameter int STARVE_LIMIT = 200
) (
    input  logic        CLK_14M,
    input  logic        reset_n,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [17:0] core_addr,
    input  logic [7:0]  core_di,
    input  logic        core_aux,
    output logic        ram_we,
    output logic [17:0] ram_addr,
    output logic [7:0]  ram_di,
    output logic        ram_aux,
    input  logic [15:0] ram_do,
    input  logic        dma_valid,
    output logic        dma_ready,
    input  logic        dma_we,
    input  logic [17:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_aux,
    output logic        dma_rvalid,
    output logic [7:0]  dma_rdata,
    output logic        init_busy,
    output logic        dma_starved
);

    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
        $error("RD_LAT must be 1..3");
    end
    if (CLEAR_DEPTH < 1 || CLEAR_DEPTH > 262144) begin : g_bad_clear_depth
        $error("CLEAR_DEPTH must be 1..262144");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must be 1..255");
    end

`ifdef APPLE2_RAM_CLEAR_EN
    typedef enum logic [1:0] {CLEAR = 2'd0, IDLE = 2'd1, PEND = 2'd2} state_t;
    localparam state_t RST_STATE = CLEAR;
    localparam logic [17:0] CLR_LAST = 18'(CLEAR_DEPTH - 1);
    logic [17:0] clr_addr;
    logic        clr_aux;
`else
    typedef enum logic [1:0] {IDLE = 2'd1, PEND = 2'd2} state_t;
    localparam state_t RST_STATE = IDLE;
`endif

    localparam logic [1:0] RD_CNT_INIT = 2'(RD_LAT);
    localparam logic [7:0] STARVE_LAST = 8'(STARVE_LIMIT - 1);

    state_t     state;
    logic [1:0] rd_cnt;
    logic       rd_aux;
    logic [7:0] starve_cnt;
    logic       dma_hs;

    assign dma_ready = (state == IDLE) & ~core_req & reset_n;
    assign dma_hs    = dma_valid & dma_ready;

    always_comb begin
        ram_we   = reset_n & core_req & core_we;
        ram_addr = core_addr;
        ram_di   = core_di;
        ram_aux  = core_aux;
        if (dma_hs) begin
            ram_we   = dma_we;
            ram_addr = dma_addr;
            ram_di   = dma_wdata;
            ram_aux  = dma_aux;
        end
`ifdef APPLE2_RAM_CLEAR_EN
        if (state == CLEAR) begin
            ram_we   = reset_n;
            ram_addr = clr_addr;
            ram_di   = 8'h00;
            ram_aux  = clr_aux;
        end
`endif
    end

    always_ff @(posedge CLK_14M or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RST_STATE;
            rd_cnt     <= '0;
            rd_aux     <= 1'b0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= 8'h00;
`ifdef APPLE2_RAM_CLEAR_EN
            clr_addr   <= '0;
            clr_aux    <= 1'b0;
            init_busy  <= 1'b1;
`endif
        end else begin
            dma_rvalid <= 1'b0;
            case (state)
`ifdef APPLE2_RAM_CLEAR_EN
                CLEAR: begin
                    // Sweep the main bank, then the aux bank, one write per cycle
                    if (clr_addr == CLR_LAST) begin
                        clr_addr <= '0;
                        if (clr_aux) begin
                            state     <= IDLE;
                            init_busy <= 1'b0;
                        end else begin
                            clr_aux <= 1'b1;
                        end
                    end else begin
                        clr_addr <= clr_addr + 18'd1;
                    end
                end
`endif
                IDLE: begin
                    if (dma_hs && !dma_we) begin
                        state  <= PEND;
                        rd_cnt <= RD_CNT_INIT;
                        rd_aux <= dma_aux;
                    end
                end
                PEND: begin
                    // rd_cnt==1 marks the cycle ram_do is valid; rd_cnt==0 is the rvalid cycle
                    if (rd_cnt == 2'd0) begin
                        state <= IDLE;
                    end else begin
                        rd_cnt <= rd_cnt - 2'd1;
                        if (rd_cnt == 2'd1) begin
                            dma_rvalid <= 1'b1;
                            dma_rdata  <= rd_aux ? ram_do[15:8] : ram_do[7:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef APPLE2_RAM_CLEAR_EN
    assign init_busy = 1'b0;
`endif

    always_ff @(posedge CLK_14M or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt  <= '0;
            dma_starved <= 1'b0;
        end else if (!dma_valid || dma_hs) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (starve_cnt != 8'hFF) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
            if (starve_cnt >= STARVE_LAST) begin
                dma_starved <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apple2_ram_arbiter.sv
// tb/tb_apple2_ram_arbiter.sv - self-checking bench for apple2_ram_arbiter
module tb_apple2_ram_arbiter;

    localparam int RD_LAT       = 1;
    localparam int CLEAR_DEPTH  = 8;
    localparam int STARVE_LIMIT = 4;
`ifdef APPLE2_RAM_CLEAR_EN
    localparam int CLR_EN = 1;
`else
    localparam int CLR_EN = 0;
`endif

    logic        CLK_14M = 1'b0;
    logic        reset_n;
    logic        core_req, core_we, core_aux;
    logic [17:0] core_addr;
    logic [7:0]  core_di;
    logic        ram_we, ram_aux;
    logic [17:0] ram_addr;
    logic [7:0]  ram_di;
    logic [15:0] ram_do;
    logic        dma_valid, dma_ready, dma_we, dma_aux;
    logic [17:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_rvalid;
    logic [7:0]  dma_rdata;
    logic        init_busy, dma_starved;

    always #5 CLK_14M = ~CLK_14M;

    apple2_ram_arbiter #(
        .RD_LAT(RD_LAT), .CLEAR_DEPTH(CLEAR_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .CLK_14M(CLK_14M), .reset_n(reset_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_di(core_di), .core_aux(core_aux),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_aux(ram_aux),
        .ram_do(ram_do),
        .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_aux(dma_aux),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .init_busy(init_busy), .dma_starved(dma_starved)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: cycle-indexed bookkeeping of what the arbiter has promised
    int         cyc         = 0;
    int         m_block_end = -1;
    int         m_cap_cyc   = -1;
    int         m_rv_cyc    = -1;
    int         m_wait      = 0;
    int         m_clear_left = 0;
    logic       m_cap_aux   = 1'b0;
    logic [7:0] m_rdata     = 8'h00;
    logic       m_starved   = 1'b0;

    always @(posedge CLK_14M) begin
        logic idle_m, rdy_m;
        idle_m = (m_clear_left == 0) && (cyc > m_block_end);
        rdy_m  = reset_n && idle_m && !core_req;
        if (!reset_n) begin
            m_block_end  = -1;
            m_cap_cyc    = -1;
            m_rv_cyc     = -1;
            m_wait       = 0;
            m_rdata      = 8'h00;
            m_starved    = 1'b0;
            m_clear_left = CLR_EN * 2 * CLEAR_DEPTH;
        end else begin
            if (m_clear_left > 0) begin
                m_clear_left--;
            end else begin
                if (cyc == m_cap_cyc)
                    m_rdata = m_cap_aux ? ram_do[15:8] : ram_do[7:0];
                if (dma_valid && rdy_m && !dma_we) begin
                    m_cap_cyc   = cyc + RD_LAT;
                    m_rv_cyc    = cyc + RD_LAT + 1;
                    m_block_end = cyc + RD_LAT + 1;
                    m_cap_aux   = dma_aux;
                end
            end
            if (!dma_valid || rdy_m) begin
                m_wait = 0;
            end else if (idle_m) begin
                if (m_wait < 255) m_wait++;
                if (m_wait >= STARVE_LIMIT) m_starved = 1'b1;
            end
        end
        cyc++;
    end

    always @(negedge CLK_14M) begin
        logic idle_m, rdy_m, hs_m;
        int   k;
        idle_m = (m_clear_left == 0) && (cyc > m_block_end);
        rdy_m  = reset_n && idle_m && !core_req;
        hs_m   = rdy_m && dma_valid;
        if (!reset_n) begin
            chk("m_rst_ram_we", 32'(ram_we), 0);
            chk("m_rst_dma_ready", 32'(dma_ready), 0);
            chk("m_rst_dma_rvalid", 32'(dma_rvalid), 0);
            chk("m_rst_dma_rdata", 32'(dma_rdata), 0);
            chk("m_rst_dma_starved", 32'(dma_starved), 0);
            chk("m_rst_init_busy", 32'(init_busy), CLR_EN);
        end else if (m_clear_left > 0) begin
            k = 2 * CLEAR_DEPTH - m_clear_left;
            chk("m_clr_ram_addr", 32'(ram_addr), k % CLEAR_DEPTH);
            chk("m_clr_ram_aux", 32'(ram_aux), k / CLEAR_DEPTH);
            chk("m_clr_ram_we", 32'(ram_we), 1);
            chk("m_clr_ram_di", 32'(ram_di), 0);
            chk("m_clr_dma_ready", 32'(dma_ready), 0);
            chk("m_clr_init_busy", 32'(init_busy), 1);
        end else begin
            chk("m_init_busy", 32'(init_busy), 0);
            chk("m_dma_ready", 32'(dma_ready), 32'(rdy_m));
            if (hs_m) begin
                chk("m_dma_ram_we", 32'(ram_we), 32'(dma_we));
                chk("m_dma_ram_addr", 32'(ram_addr), 32'(dma_addr));
                chk("m_dma_ram_aux", 32'(ram_aux), 32'(dma_aux));
                if (dma_we) chk("m_dma_ram_di", 32'(ram_di), 32'(dma_wdata));
            end else begin
                chk("m_core_ram_we", 32'(ram_we), 32'(core_req && core_we));
                chk("m_core_ram_addr", 32'(ram_addr), 32'(core_addr));
                chk("m_core_ram_aux", 32'(ram_aux), 32'(core_aux));
                chk("m_core_ram_di", 32'(ram_di), 32'(core_di));
            end
            chk("m_dma_rvalid", 32'(dma_rvalid), 32'(cyc == m_rv_cyc));
            chk("m_dma_rdata", 32'(dma_rdata), 32'(m_rdata));
            chk("m_dma_starved", 32'(dma_starved), 32'(m_starved));
        end
    end

    task automatic nxt();
        @(posedge CLK_14M);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK_14M);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        core_req = 1'b1; core_we = 1'b1; core_addr = 18'h00123; core_di = 8'h77; core_aux = 1'b0;
        ram_do = 16'h0000;
        dma_valid = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = 8'h00; dma_aux = 1'b0;
        smp();
        chk("reset_ram_we", 32'(ram_we), 0);
        chk("reset_dma_ready", 32'(dma_ready), 0);
        chk("reset_dma_rdata", 32'(dma_rdata), 0);
        nxt(); nxt();
        reset_n = 1'b1; core_req = 1'b0; core_we = 1'b0;
`ifdef APPLE2_RAM_CLEAR_EN
        for (int k = 0; k < 16; k++) begin
            smp();
            chk("sweep_addr", 32'(ram_addr), k % 8);
            chk("sweep_aux", 32'(ram_aux), k / 8);
            chk("sweep_we", 32'(ram_we), 1);
            chk("sweep_busy", 32'(init_busy), 1);
            nxt();
        end
`endif
        smp();
        chk("init_busy_low", 32'(init_busy), 0);
        nxt();
        // core wins over a simultaneous DMA request
        core_req = 1'b1; core_we = 1'b1; core_addr = 18'h003F4; core_di = 8'h11;
        dma_valid = 1'b1; dma_we = 1'b1; dma_addr = 18'h01000; dma_wdata = 8'hA5;
        smp();
        chk("t1_ram_addr", 32'(ram_addr), 32'h003F4);
        chk("t1_dma_ready", 32'(dma_ready), 0);
        chk("t1_ram_we", 32'(ram_we), 1);
        nxt();
        core_req = 1'b0; core_we = 1'b0;
        smp();
        chk("t2_ram_addr", 32'(ram_addr), 32'h01000);
        chk("t2_ram_di", 32'(ram_di), 32'hA5);
        chk("t2_ram_we", 32'(ram_we), 1);
        chk("t2_dma_ready", 32'(dma_ready), 1);
        nxt();
        dma_addr = 18'h01001; dma_wdata = 8'h5A; dma_aux = 1'b1;
        smp();
        chk("t2b_ram_addr", 32'(ram_addr), 32'h01001);
        chk("t2b_ram_aux", 32'(ram_aux), 1);
        chk("t2b_dma_ready", 32'(dma_ready), 1);
        nxt();
        dma_valid = 1'b0; dma_we = 1'b0; dma_aux = 1'b0;
        smp();
        chk("t2c_ram_we", 32'(ram_we), 0);
        nxt();
        // aux read, core uses the bus while it is pending
        dma_valid = 1'b1; dma_we = 1'b0; dma_aux = 1'b1; dma_addr = 18'h02000;
        smp();
        chk("t3_T_ready", 32'(dma_ready), 1);
        chk("t3_T_ram_addr", 32'(ram_addr), 32'h02000);
        nxt();
        dma_valid = 1'b0; ram_do = 16'h5A3C; core_req = 1'b1; core_we = 1'b1; core_addr = 18'h00400;
        smp();
        chk("t3_T1_ready", 32'(dma_ready), 0);
        chk("t3_T1_ram_addr", 32'(ram_addr), 32'h00400);
        chk("t3_T1_rvalid", 32'(dma_rvalid), 0);
        nxt();
        ram_do = 16'hFFFF; core_req = 1'b0; core_we = 1'b0;
        dma_valid = 1'b1; dma_aux = 1'b0; dma_addr = 18'h02001;
        smp();
        chk("t3_T2_rvalid", 32'(dma_rvalid), 1);
        chk("t3_T2_rdata", 32'(dma_rdata), 32'h5A);
        chk("t3_T2_ready", 32'(dma_ready), 0);
        nxt();
        smp();
        chk("t3b_T_ready", 32'(dma_ready), 1);
        chk("t3b_T_rvalid", 32'(dma_rvalid), 0);
        chk("t3b_T_rdata_hold", 32'(dma_rdata), 32'h5A);
        nxt();
        dma_valid = 1'b0; ram_do = 16'h5A3C;
        smp();
        nxt();
        ram_do = 16'h0000;
        smp();
        chk("t3b_T2_rvalid", 32'(dma_rvalid), 1);
        chk("t3b_T2_rdata", 32'(dma_rdata), 32'h3C);
        nxt();
        // abandoned requests clear the wait count
        core_req = 1'b1; dma_valid = 1'b1; dma_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp(); chk("abandon_a_starved", 32'(dma_starved), 0); nxt();
        end
        dma_valid = 1'b0;
        smp(); nxt();
        dma_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp(); chk("abandon_b_starved", 32'(dma_starved), 0); nxt();
        end
        dma_valid = 1'b0;
        smp(); chk("abandon_c_starved", 32'(dma_starved), 0); nxt();
        // starvation
        dma_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            smp();
            chk("t4_starved", 32'(dma_starved), 32'(i >= 5));
            chk("t4_ready", 32'(dma_ready), 0);
            nxt();
        end
        core_req = 1'b0; core_we = 1'b0; dma_valid = 1'b0;
        smp();
        chk("t4_starved_sticky", 32'(dma_starved), 1);
        nxt();
        // reset lands while a read is pending
        dma_valid = 1'b1; dma_we = 1'b0; dma_aux = 1'b1; dma_addr = 18'h02002; ram_do = 16'h7788;
        smp();
        chk("t5_T_ready", 32'(dma_ready), 1);
        nxt();
        dma_valid = 1'b0; reset_n = 1'b0; core_req = 1'b1; core_we = 1'b1;
        smp();
        chk("t5_rst_ram_we", 32'(ram_we), 0);
        chk("t5_rst_starved", 32'(dma_starved), 0);
        nxt();
        reset_n = 1'b1; core_req = 1'b0; core_we = 1'b0;
        for (int i = 0; i < 24; i++) begin
            smp();
            chk("t5_no_rvalid", 32'(dma_rvalid), 0);
            chk("t5_rdata_zero", 32'(dma_rdata), 0);
            nxt();
        end
        smp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
